// File: rtl/background_scanner.sv
// Raster scanner that walks the background lookup over one full frame and
// forwards each looked-up colour to the VGA adapter with matching coordinates.
module background_scanner #(
  parameter int WIDTH  = 320,
  parameter int HEIGHT = 240
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic       pause,
  input  logic [2:0] colour_in,
  output logic [8:0] x_cord,
  output logic [8:0] y_cord,
  output logic [8:0] vga_x,
  output logic [7:0] vga_y,
  output logic [2:0] vga_colour,
  output logic       plot,
  output logic       busy,
  output logic       done
);

  typedef enum logic [1:0] {IDLE, SCAN, FLUSH, DONE} state_t;

  localparam logic [8:0] X_LAST = 9'(WIDTH - 1);
  localparam logic [8:0] Y_LAST = 9'(HEIGHT - 1);

  state_t state, state_next;
  logic   issue;
  logic   last_x;
  logic   last_pixel;

  always_comb begin
    state_next = state;
    issue      = (state == SCAN) && !pause;
    last_x     = (x_cord == X_LAST);
    last_pixel = last_x && (y_cord == Y_LAST);
    busy       = (state == SCAN) || (state == FLUSH);
    done       = (state == DONE);
    case (state)
      IDLE:    if (start) state_next = SCAN;
      SCAN:    if (issue && last_pixel) state_next = FLUSH;
      FLUSH:   state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // The lookup stage registers its colour, so the plot coordinates and the
  // write-enable are delayed one cycle to line up with colour_in.
  always_ff @(posedge clock) begin
    if (reset) begin
      state  <= IDLE;
      x_cord <= '0;
      y_cord <= '0;
      vga_x  <= '0;
      vga_y  <= '0;
      plot   <= 1'b0;
    end else begin
      state <= state_next;
      vga_x <= x_cord;
      vga_y <= y_cord[7:0];
      plot  <= issue;
      if (state == IDLE && start) begin
        x_cord <= '0;
        y_cord <= '0;
      end else if (issue && !last_pixel) begin
        if (last_x) begin
          x_cord <= '0;
          y_cord <= y_cord + 9'd1;
        end else begin
          x_cord <= x_cord + 9'd1;
        end
      end
    end
  end

  assign vga_colour = colour_in;

endmodule

// File: tb/tb_background_scanner.sv
// Self-checking bench: a full-size scanner for the frame-level checks and a
// small one for mid-frame reset and randomized pause frames.
module tb_background_scanner;

  localparam int BW = 320;
  localparam int BH = 240;
  localparam int BN = BW * BH;
  localparam int SW = 24;
  localparam int SH = 10;
  localparam int SN = SW * SH;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  // Behavioural background picture; the fixed regions pin the known colours.
  function automatic logic [2:0] bg(input int x, input int y);
    if (y >= 230 || (x < 20 && y < 20)) return 3'b111;
    if (x >= 200 && y < 60) return 3'b110;
    if (x >= 90 && x < 110 && y >= 90 && y < 110) return 3'b000;
    return 3'((x + 3 * y) % 7);
  endfunction

  logic       b_reset, b_start, b_pause;
  logic [2:0] b_colour_in;
  logic [8:0] b_x_cord, b_y_cord, b_vga_x;
  logic [7:0] b_vga_y;
  logic [2:0] b_vga_colour;
  logic       b_plot, b_busy, b_done;

  logic       s_reset, s_start, s_pause;
  logic [2:0] s_colour_in;
  logic [8:0] s_x_cord, s_y_cord, s_vga_x;
  logic [7:0] s_vga_y;
  logic [2:0] s_vga_colour;
  logic       s_plot, s_busy, s_done;

  background_scanner dut_big (
    .clock(clock), .reset(b_reset), .start(b_start), .pause(b_pause),
    .colour_in(b_colour_in), .x_cord(b_x_cord), .y_cord(b_y_cord),
    .vga_x(b_vga_x), .vga_y(b_vga_y), .vga_colour(b_vga_colour),
    .plot(b_plot), .busy(b_busy), .done(b_done)
  );

  background_scanner #(.WIDTH(SW), .HEIGHT(SH)) dut_small (
    .clock(clock), .reset(s_reset), .start(s_start), .pause(s_pause),
    .colour_in(s_colour_in), .x_cord(s_x_cord), .y_cord(s_y_cord),
    .vga_x(s_vga_x), .vga_y(s_vga_y), .vga_colour(s_vga_colour),
    .plot(s_plot), .busy(s_busy), .done(s_done)
  );

  always @(posedge clock) begin
    b_colour_in <= bg(int'(b_x_cord), int'(b_y_cord));
    s_colour_in <= bg(int'(s_x_cord), int'(s_y_cord));
  end

  int b_plots = 0, b_order_err = 0, b_col_err = 0, b_done_cnt = 0, b_done_cyc = -1;
  int b_low = 0, b_prev_x = -1, b_prev_y = -1, b_resume = -1;
  bit b_prev_low = 0;

  // Model: the k-th plot of a frame must be pixel (k % W, k / W).
  always @(negedge clock) begin
    if (b_done) begin
      b_done_cnt++;
      b_done_cyc = cyc;
    end
    if (b_plot) begin
      if (int'(b_vga_x) != b_plots % BW || int'(b_vga_y) != b_plots / BW) b_order_err++;
      if (b_vga_colour !== bg(b_plots % BW, b_plots / BW)) b_col_err++;
      if (b_plots == 0)     checkOutput("colour_0_0", b_vga_colour, 3'b111);
      if (b_plots == 32100) checkOutput("colour_100_100", b_vga_colour, 3'b000);
      if (b_plots == 9840)  checkOutput("colour_240_30", b_vga_colour, 3'b110);
      if (b_plots == 75850) checkOutput("colour_10_237", b_vga_colour, 3'b111);
      if (b_plots == 320) begin
        checkOutput("wrap0_prev", b_prev_y * 512 + b_prev_x, 0 * 512 + 319);
        checkOutput("wrap0_next", b_vga_y * 512 + b_vga_x, 1 * 512 + 0);
      end
      if (b_plots == 239 * 320) begin
        checkOutput("wrap238_prev", b_prev_y * 512 + b_prev_x, 238 * 512 + 319);
        checkOutput("wrap238_next", b_vga_y * 512 + b_vga_x, 239 * 512 + 0);
      end
      if (b_prev_low) b_resume = b_vga_y * 512 + b_vga_x;
      b_prev_x = int'(b_vga_x);
      b_prev_y = int'(b_vga_y);
      b_prev_low = 0;
      b_plots++;
    end else if (b_busy && b_plots > 0) begin
      b_low++;
      b_prev_low = 1;
    end
  end

  int s_plots = 0, s_order_err = 0, s_col_err = 0, s_done_cnt = 0, s_done_cyc = -1;

  always @(negedge clock) begin
    if (s_done) begin
      s_done_cnt++;
      s_done_cyc = cyc;
    end
    if (s_plot) begin
      if (int'(s_vga_x) != s_plots % SW || int'(s_vga_y) != s_plots / SW) s_order_err++;
      if (s_vga_colour !== bg(s_plots % SW, s_plots / SW)) s_col_err++;
      s_plots++;
    end
  end

  // Runs one small frame with random pause; the expected done cycle comes
  // from counting issue opportunities the pause pattern leaves open.
  task automatic applyStimulus(input int pause_odds, output int st, output int exp_done);
    int n;
    s_plots = 0; s_order_err = 0; s_col_err = 0; s_done_cnt = 0; s_done_cyc = -1;
    exp_done = -1;
    s_pause = 0;
    s_start = 1;
    st = cyc;
    @(negedge clock);
    s_start = 0;
    n = 0;
    for (int k = 1; k < SN * 8 + 50 && !s_done; k++) begin
      s_pause = (pause_odds > 0) && ($urandom_range(0, pause_odds - 1) == 0);
      if (n < SN && !s_pause) begin
        n++;
        if (n == SN) exp_done = k + 2;
      end
      @(negedge clock);
    end
    s_pause = 0;
    repeat (3) @(negedge clock);
  endtask

  task automatic checkSmallFrame(input string tag, input int st, input int exp_done);
    checkOutput({tag, "_plots"}, s_plots, SN);
    checkOutput({tag, "_order"}, s_order_err, 0);
    checkOutput({tag, "_colour"}, s_col_err, 0);
    checkOutput({tag, "_done_cnt"}, s_done_cnt, 1);
    checkOutput({tag, "_done_cyc"}, s_done_cyc - st, exp_done);
    checkOutput({tag, "_busy_after"}, s_busy, 0);
  endtask

  initial begin
    int b_st, st, exp_done, k;
    bit busy_seen;
    b_reset = 1; b_start = 1; b_pause = 1;
    s_reset = 1; s_start = 0; s_pause = 0;
    repeat (2) @(negedge clock);
    checkOutput("rst_x", b_x_cord, 0);
    checkOutput("rst_y", b_y_cord, 0);
    checkOutput("rst_vga_x", b_vga_x, 0);
    checkOutput("rst_vga_y", b_vga_y, 0);
    checkOutput("rst_plot", b_plot, 0);
    checkOutput("rst_busy", b_busy, 0);
    checkOutput("rst_done", b_done, 0);
    b_reset = 0; b_start = 0; b_pause = 0; s_reset = 0;
    repeat (2) @(negedge clock);
    checkOutput("idle_plot", b_plot, 0);

    b_plots = 0; b_order_err = 0; b_col_err = 0; b_done_cnt = 0; b_low = 0;
    b_start = 1;
    b_st = cyc;
    @(negedge clock);
    b_start = 0;
    @(negedge clock);
    b_start = 1;
    @(negedge clock);
    b_start = 0;
    for (k = 0; k < 5000 && !(b_x_cord == 50 && b_y_cord == 3); k++) @(negedge clock);
    checkOutput("pause_reach", {b_y_cord, b_x_cord}, {9'd3, 9'd50});
    b_pause = 1;
    repeat (5) @(negedge clock);
    b_pause = 0;
    for (k = 0; k < BN + 100 && !b_done; k++) @(negedge clock);
    checkOutput("big_done_seen", b_done, 1);
    b_start = 1;
    @(negedge clock);
    b_start = 0;
    busy_seen = 0;
    repeat (20) begin
      busy_seen |= b_busy;
      @(negedge clock);
    end
    checkOutput("big_plots", b_plots, BN);
    checkOutput("big_order", b_order_err, 0);
    checkOutput("big_colour", b_col_err, 0);
    checkOutput("big_done_cnt", b_done_cnt, 1);
    checkOutput("big_done_cyc", b_done_cyc - b_st, BN + 2 + 5);
    checkOutput("big_busy_after", busy_seen, 0);
    checkOutput("pause_low_cycles", b_low, 5);
    checkOutput("pause_resume_px", b_resume, 3 * 512 + 50);

    s_start = 1;
    @(negedge clock);
    s_start = 0;
    for (k = 0; k < SN * 2 && s_y_cord != 5; k++) @(negedge clock);
    checkOutput("mid_reach_y", s_y_cord, 5);
    s_reset = 1;
    @(negedge clock);
    checkOutput("mid_rst_plot", s_plot, 0);
    checkOutput("mid_rst_busy", s_busy, 0);
    checkOutput("mid_rst_done", s_done, 0);
    checkOutput("mid_rst_xy", {s_y_cord, s_x_cord}, 0);
    s_reset = 0;
    @(negedge clock);

    applyStimulus(0, st, exp_done);
    checkSmallFrame("post_reset", st, exp_done);
    for (int f = 0; f < 3; f++) begin
      applyStimulus(3, st, exp_done);
      checkSmallFrame($sformatf("rand%0d", f), st, exp_done);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/background_scanner.md
BACKGROUND_SCANNER -- requirements
Module: background_scanner

Interface
REQ-001 SHALL have parameter WIDTH, default 320, meaning pixels per line (x range 0..WIDTH-1).
REQ-002 SHALL have parameter HEIGHT, default 240, meaning lines per frame (y range 0..HEIGHT-1).
REQ-003 SHALL have port clock  input  1  system clock; all state changes on the rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port start  input  1  request to scan one full frame; sampled only in IDLE.
REQ-006 SHALL have port pause  input  1  stall request from the VGA side; holds scan position while high.
REQ-007 SHALL have port colour_in  input  3  registered colour from the background colour-lookup stage, one cycle after x_cord/y_cord.
REQ-008 SHALL have port x_cord  output  9  x coordinate presented to the background lookup.
REQ-009 SHALL have port y_cord  output  9  y coordinate presented to the background lookup.
REQ-010 SHALL have port vga_x  output  9  x of the pixel being plotted.
REQ-011 SHALL have port vga_y  output  8  y of the pixel being plotted.
REQ-012 SHALL have port vga_colour  output  3  colour of the pixel being plotted; equals colour_in.
REQ-013 SHALL have port plot  output  1  write-enable to the VGA adapter; vga_x, vga_y and vga_colour are valid while high.
REQ-014 SHALL have port busy  output  1  high in SCAN and FLUSH.
REQ-015 SHALL have port done  output  1  one-cycle pulse at frame completion.

Function
REQ-016 SHALL implement FSM states IDLE, SCAN, FLUSH and DONE.
REQ-017 SHALL move IDLE->SCAN when start=1, loading x_cord=0 and y_cord=0; start in any other state SHALL be ignored.
REQ-018 SHALL define issue = (state==SCAN && pause==0); a pixel is issued on each edge where issue=1.
REQ-019 SHALL, on each issue edge, advance the counters as follows:
- x_cord increments by 1.
- At x_cord==WIDTH-1, x_cord wraps to 0 and y_cord increments by 1.
REQ-020 SHALL move SCAN->FLUSH on the issue edge for (WIDTH-1, HEIGHT-1) and SHALL leave x_cord/y_cord at that value.
REQ-021 SHALL register, on every edge, vga_x<=x_cord, vga_y<=y_cord[7:0] and plot<=issue, so that plot/vga_x/vga_y align with colour_in (1-cycle latency).
REQ-022 SHALL move FLUSH->DONE unconditionally after 1 cycle; the last pixel's plot is high during FLUSH.
REQ-023 SHALL assert done=1 for exactly the single DONE cycle, then move DONE->IDLE.
REQ-024 SHALL, while pause=1 in SCAN, hold x_cord/y_cord and drive plot=0 on the following cycle; on resume it SHALL reissue the held coordinate, with no pixel skipped or duplicated.
REQ-025 SHALL, with pause held low, produce exactly WIDTH*HEIGHT plot cycles per frame in raster order, one per cycle.
REQ-026 SHALL, with pause held low, have the first plot high in the cycle after the start edge and done high 2 cycles after the last-pixel issue edge.
REQ-027 SHALL NOT let pause affect FLUSH or DONE.
REQ-028 SHALL hold x_cord/y_cord in IDLE and SHALL keep plot=0 there.

Reset
REQ-029 SHALL, when reset=1 at an edge in any state, force the following regardless of start or pause:
- State = IDLE.
- x_cord = y_cord = 0.
- vga_x = vga_y = 0.
- plot = busy = done = 0.
REQ-030 SHALL, on reset mid-frame, discard the remainder of the frame; the next start SHALL restart from (0,0).

Verification
REQ-031 Full frame: with background attached, pause=0, pulse start -> the bench SHALL check:
- Exactly 76800 plot cycles, in raster order.
- done high once, 76802 cycles after the start edge.
- busy low afterward.
REQ-032 Colour alignment: same frame -> the bench SHALL check these plotted colours:
- (0,0) = 3'b111.
- (100,100) = 3'b000.
- (240,30) = 3'b110.
- (10,237) = 3'b111.
REQ-033 Wrap: the plot after (319,0) SHALL be (0,1); the plot after (319,238) SHALL be (0,239).
REQ-034 Pause: assert pause for 5 cycles while x_cord=50, y_cord=3 -> the bench SHALL check:
- 5 plot-low cycles.
- Next plotted pixel is (50,3).
- Total frame plots still 76800.
REQ-035 Reset mid-op: assert reset at y_cord=100 -> next cycle plot=0, busy=0, x_cord=y_cord=0; a subsequent start SHALL yield a full 76800-pixel frame.
REQ-036 Start ignored: pulse start during SCAN and again during DONE -> no restart, no extra done; the frame completes normally.
